// File: rtl/simple_rr_arbiter_if.sv
// Request/grant bundle between three requesters and the shared-unit arbiter.
// master = requester side, slave = arbiter side.
interface simple_rr_arbiter_if;
  logic       req_1;
  logic       req_2;
  logic       req_3;
  logic       gnt_1;
  logic       gnt_2;
  logic       gnt_3;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req_1, req_2, req_3,
    input  gnt_1, gnt_2, gnt_3, gnt_id, busy, timeout
  );

  modport slave (
    input  req_1, req_2, req_3,
    output gnt_1, gnt_2, gnt_3, gnt_id, busy, timeout
  );
endinterface

// File: rtl/simple_rr_arbiter.sv
// Three-way round-robin arbiter for a shared reduce unit. A grant is held while
// the owner keeps requesting, up to MAX_HOLD cycles, then forcibly revoked.
module simple_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  simple_rr_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic [1:0]       last_reg;
  logic [2:0]       gnt_reg;
  logic [1:0]       gnt_id_reg;
  logic             busy_reg;
  logic             timeout_reg;

  logic [2:0]       req_vec;
  logic             owner_req;
  logic [1:0]       pick_id;
  logic             pick_valid;
  logic [2:0]       pick_onehot;

  assign req_vec   = {bus.req_3, bus.req_2, bus.req_1};
  assign owner_req = |(req_vec & gnt_reg);

  // Search starts at the requester after last_reg and wraps 1->2->3->1.
  always_comb begin
    pick_id = 2'd0;
    case (last_reg)
      2'd1: begin
        if      (req_vec[1]) pick_id = 2'd2;
        else if (req_vec[2]) pick_id = 2'd3;
        else if (req_vec[0]) pick_id = 2'd1;
      end
      2'd2: begin
        if      (req_vec[2]) pick_id = 2'd3;
        else if (req_vec[0]) pick_id = 2'd1;
        else if (req_vec[1]) pick_id = 2'd2;
      end
      default: begin
        if      (req_vec[0]) pick_id = 2'd1;
        else if (req_vec[1]) pick_id = 2'd2;
        else if (req_vec[2]) pick_id = 2'd3;
      end
    endcase
  end

  assign pick_valid = (pick_id != 2'd0);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_id == 2'(gi + 1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      last_reg     <= 2'd3;
      gnt_reg      <= 3'b000;
      gnt_id_reg   <= 2'd0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          timeout_reg <= 1'b0;
          if (pick_valid) begin
            state_reg    <= ST_GRANT;
            gnt_reg      <= pick_onehot;
            gnt_id_reg   <= pick_id;
            last_reg     <= pick_id;
            hold_cnt_reg <= '0;
            busy_reg     <= 1'b1;
          end
        end
        ST_GRANT: begin
          // A voluntary drop wins over the hold limit: no timeout on that edge.
          if (!owner_req) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= 3'b000;
            gnt_id_reg   <= 2'd0;
            busy_reg     <= 1'b0;
            hold_cnt_reg <= '0;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            state_reg    <= ST_RELEASE;
            gnt_reg      <= 3'b000;
            gnt_id_reg   <= 2'd0;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b1;
            hold_cnt_reg <= '0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          state_reg   <= ST_IDLE;
          timeout_reg <= 1'b0;
        end
        default: begin
          state_reg    <= ST_IDLE;
          gnt_reg      <= 3'b000;
          gnt_id_reg   <= 2'd0;
          busy_reg     <= 1'b0;
          timeout_reg  <= 1'b0;
          hold_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign bus.gnt_1   = gnt_reg[0];
  assign bus.gnt_2   = gnt_reg[1];
  assign bus.gnt_3   = gnt_reg[2];
  assign bus.gnt_id  = gnt_id_reg;
  assign bus.busy    = busy_reg;
  assign bus.timeout = timeout_reg;

endmodule

// File: tb/tb_simple_rr_arbiter.sv
// Bench for simple_rr_arbiter: directed scenarios plus randomized requests,
// all checked cycle by cycle against a behavioural grant/hold model.
module tb_simple_rr_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic reset;

  simple_rr_arbiter_if bus ();

  simple_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: who owns the unit, how many cycles it has seen its grant,
  // whether we are in the dead cycle after a revocation, and who went last.
  int m_owner = 0;
  int m_held  = 0;
  int m_cool  = 0;
  int m_last  = 3;
  int m_to    = 0;

  // Observations of the DUT used by scenario-level checks.
  int   gq[$];
  logic [1:0] prev_id = 2'd0;
  int   to_cnt   = 0;
  int   idle_cnt = 0;
  int   hi_cnt [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_obs();
    gq.delete();
    to_cnt   = 0;
    idle_cnt = 0;
    for (int i = 0; i < 3; i++) hi_cnt[i] = 0;
  endtask

  task automatic model_edge(input logic r, input logic [2:0] rq);
    if (r) begin
      m_owner = 0; m_held = 0; m_cool = 0; m_last = 3; m_to = 0;
    end else if (m_owner != 0) begin
      m_to = 0;
      if (!rq[m_owner-1]) begin
        m_owner = 0;
      end else if (m_held == MAX_HOLD) begin
        m_owner = 0; m_to = 1; m_cool = 1;
      end else begin
        m_held++;
      end
    end else if (m_cool != 0) begin
      m_cool = 0; m_to = 0;
    end else begin
      m_to = 0;
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k - 1) % 3 + 1;
        if (m_owner == 0 && rq[c-1]) begin
          m_owner = c; m_last = c; m_held = 1;
          $display("[TB] cycle %0d grant to requester %0d", cyc, c);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [2:0] rq);
    logic [2:0] exp_gnt;
    reset     = r;
    bus.req_1 = rq[0];
    bus.req_2 = rq[1];
    bus.req_3 = rq[2];
    @(posedge clk);
    cyc++;
    model_edge(r, rq);
    #1;
    exp_gnt = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));
    check_eq("gnt",     {29'd0, bus.gnt_3, bus.gnt_2, bus.gnt_1}, {29'd0, exp_gnt});
    check_eq("gnt_id",  {30'd0, bus.gnt_id}, m_owner);
    check_eq("busy",    {31'd0, bus.busy}, (m_owner != 0) ? 32'd1 : 32'd0);
    check_eq("timeout", {31'd0, bus.timeout}, m_to);
    if (bus.gnt_id !== 2'd0 && prev_id === 2'd0) gq.push_back(int'(bus.gnt_id));
    else if (bus.gnt_id === 2'd0 && gq.size() != 0) idle_cnt++;
    prev_id = bus.gnt_id;
    if (bus.timeout === 1'b1) to_cnt++;
    if (bus.gnt_1 === 1'b1) hi_cnt[0]++;
    if (bus.gnt_2 === 1'b1) hi_cnt[1]++;
    if (bus.gnt_3 === 1'b1) hi_cnt[2]++;
  endtask

  initial begin
    logic [2:0] rq;
    int n;

    // Reset, then all three requesting continuously: 10-cycle rotation.
    step(1'b1, 3'b000);
    step(1'b1, 3'b000);
    check_eq("rst_out", {26'd0, bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_id, bus.busy, bus.timeout}, 32'd0);
    clear_obs();
    for (int i = 0; i < 40; i++) step(1'b0, 3'b111);
    check_eq("rot_ngrants", gq.size(), 4);
    if (gq.size() >= 4) begin
      check_eq("rot_g0", gq[0], 1);
      check_eq("rot_g1", gq[1], 2);
      check_eq("rot_g2", gq[2], 3);
      check_eq("rot_g3", gq[3], 1);
    end
    check_eq("rot_timeouts", to_cnt, 4);
    check_eq("rot_hold1", hi_cnt[0], 2 * MAX_HOLD);
    check_eq("rot_hold2", hi_cnt[1], MAX_HOLD);

    // Lone req_2 for three cycles.
    step(1'b1, 3'b000);
    clear_obs();
    for (int i = 0; i < 3; i++) step(1'b0, 3'b010);
    for (int i = 0; i < 3; i++) step(1'b0, 3'b000);
    check_eq("solo_hold2", hi_cnt[1], 3);
    check_eq("solo_timeouts", to_cnt, 0);
    check_eq("solo_ngrants", gq.size(), 1);

    // Every owner lets go after two cycles: fair order, one idle cycle between.
    step(1'b1, 3'b000);
    clear_obs();
    n = 0;
    while (gq.size() < 6 && n < 100) begin
      rq = 3'b111;
      if (m_owner != 0 && m_held >= 2) rq[m_owner-1] = 1'b0;
      step(1'b0, rq);
      n++;
    end
    check_eq("fair_ngrants", gq.size(), 6);
    for (int i = 0; i < gq.size() && i < 6; i++) check_eq("fair_order", gq[i], i % 3 + 1);
    check_eq("fair_idle", idle_cnt, 5);
    check_eq("fair_timeouts", to_cnt, 0);

    // Owner drops on the last allowed hold cycle: plain release, no pulse.
    step(1'b1, 3'b000);
    clear_obs();
    n = 0;
    while (!(m_owner == 1 && m_held == MAX_HOLD) && n < 50) begin
      step(1'b0, 3'b111);
      n++;
    end
    check_eq("edge_reached", (m_owner == 1 && m_held == MAX_HOLD) ? 32'd1 : 32'd0, 32'd1);
    step(1'b0, 3'b110);
    check_eq("edge_timeout", to_cnt, 0);
    step(1'b0, 3'b010);
    check_eq("edge_regrant", {30'd0, bus.gnt_id}, 32'd2);

    // Reset in the middle of a requester-3 grant.
    step(1'b1, 3'b000);
    n = 0;
    while (m_owner != 3 && n < 60) begin
      step(1'b0, 3'b111);
      n++;
    end
    check_eq("mid_reached", (m_owner == 3) ? 32'd1 : 32'd0, 32'd1);
    step(1'b1, 3'b111);
    check_eq("mid_rst_out", {26'd0, bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_id, bus.busy, bus.timeout}, 32'd0);
    step(1'b0, 3'b111);
    check_eq("mid_first", {30'd0, bus.gnt_id}, 32'd1);

    // Random requests with sticky bits so long holds and timeouts occur.
    rq = 3'b000;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      step(($urandom_range(0, 199) == 0), rq);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
